bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Sequential binary-to-BCD conversion engine shared between several requesters. A round-robin arbiter grants one requester at a time over a valid/ready handshake. A shift-and-add-3 (double-dabble) datapath then runs one iteration per clock. The packed BCD result is returned on a single output channel tagged with the requester index. It sits between counters/measurement blocks and the display drivers, replacing per-source combinational converters.

## Interface
- NREQ, 2, number of requesters (2..8)
- BIN_W, 8, binary input width
- DIGITS, 3, BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W − 1
- ID_W, derived, max(1, ceil(log2(NREQ)))

- clk  input  1  system clock, all state changes on rising edge
- rstn  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request
- req_bin  input  NREQ*BIN_W  packed operands, requester i at [i*BIN_W +: BIN_W]
- req_ready  output  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i]
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_bcd  output  4*DIGITS  packed BCD, digit 0 (units) in [3:0]
- out_id  output  ID_W  index of requester that produced out_bcd
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, CONV, OUT.
- IDLE:
  - req_ready is combinational: one-hot on the highest-priority requester with req_valid high; all zero if none.
  - Priority order starts at (last_grant+1) mod NREQ and wraps.
  - On transfer: load shift register {4*DIGITS zeros, req_bin[i]}, clear iteration counter, capture id = i, set last_grant = i, go to CONV.
  - If req_valid drops before transfer, no grant is committed and arbitration re-evaluates every cycle.
- CONV, one iteration per cycle:
  - Every 4-bit digit field ≥ 5 gets +3, mod 16. All fields are evaluated in parallel from the current register value.
  - The whole register then shifts left by 1.
  - Counter increments each iteration. After BIN_W iterations, the upper 4*DIGITS bits are registered to out_bcd, out_id is loaded, and the state goes to OUT.
- OUT:
  - out_valid high; out_bcd and out_id held stable until out_ready.
  - On out_valid & out_ready, go to IDLE. out_bcd and out_id retain their last value.
- req_ready is all zero outside IDLE. No new request is accepted while a result is pending.
- Input values are any 0..2^BIN_W−1. No error conditions exist.
- Reset (rstn low, asynchronous, any state including mid-CONV or OUT):
  - state = IDLE; out_valid = 0; out_bcd = 0; out_id = 0; busy = 0.
  - req_ready forced 0 while rstn is low.
  - last_grant = NREQ−1, so requester 0 wins first after reset.
  - Counter and shift register are cleared; any partial conversion is discarded.

## Timing
- Request accepted at edge k. CONV spans edges k+1..k+BIN_W. out_valid is visible after edge k+BIN_W, giving latency BIN_W cycles from acceptance.
- With out_ready held high: result consumed at edge k+BIN_W+1, IDLE reached, next accept at edge k+BIN_W+2. Sustained throughput is one conversion per BIN_W+2 cycles.
- out_ready low stalls in OUT indefinitely with outputs stable.
- When requests are simultaneous, exactly one grant is issued per IDLE cycle. Fairness: with all NREQ requesters continuously valid, grants rotate strictly 0,1,…,NREQ−1,0.
- The arbitration path (req_valid → req_ready) is combinational. Every other output is registered.

## Test plan
- Single conversions from req 0, defaults:
  - 8'd0 → 12'h000
  - 8'd99 → 12'h099
  - 8'd100 → 12'h100
  - 8'd255 → 12'h255
  - Each result must arrive exactly 8 cycles after the handshake, with out_id = 0.
- Exhaustive sweep 0..255 alternating between req 0 and req 1, out_ready tied high:
  - every out_bcd matches the decimal value and out_id matches the source;
  - spacing between consecutive accepts is 10 cycles.
- Both req_valid high continuously (req 0 = 8'd12, req 1 = 8'd200) → out_id sequence 0,1,0,1… with results 12'h012 and 12'h200. req_ready is never two-hot.
- out_ready low for 20 cycles in OUT:
  - out_valid, out_bcd and out_id stay stable;
  - req_ready stays 0 despite pending req_valid;
  - on release, exactly one result transfers.
- Reset pulse mid-CONV (iteration 4 of 8'd173):
  - all outputs go to their reset values immediately (asynchronously);
  - no stale result appears after reset;
  - a subsequent request returns the correct value.
- Requester drops req_valid in IDLE the same cycle another raises it → grant goes only to the valid requester. The dropped requester's operand is never converted.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Shared binary-to-BCD converter: round-robin arbitration over NREQ requesters,
// then one double-dabble iteration per clock with a tagged result channel.
module bcd_conv_arbiter #(
  parameter  int NREQ   = 2,
  parameter  int BIN_W  = 8,
  parameter  int DIGITS = 3,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*BIN_W-1:0]   req_bin,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*DIGITS-1:0]     out_bcd,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;

  logic [ID_W-1:0]  start_idx, rot_pos, grant_idx;
  logic [ID_W:0]    idx_sum;
  logic [NREQ-1:0]  valid_rot, grant_oh;
  logic             any_valid, accept;
  logic [BIN_W-1:0] sel_bin;

  // Rotate the request vector so the search always starts at index 0, then
  // map the winning position back into requester numbering.
  always_comb begin
    start_idx = (last_grant_q == ID_W'(NREQ - 1)) ? '0 : last_grant_q + 1'b1;
    valid_rot = NREQ'({req_valid, req_valid} >> start_idx);
    any_valid = |valid_rot;
    rot_pos   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) rot_pos = ID_W'(i);
    end
    idx_sum = {1'b0, start_idx} + {1'b0, rot_pos};
    if (idx_sum >= (ID_W + 1)'(NREQ)) idx_sum = idx_sum - (ID_W + 1)'(NREQ);
    grant_idx = idx_sum[ID_W-1:0];
    grant_oh  = NREQ'(1) << grant_idx;
    sel_bin   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) sel_bin = req_bin[i*BIN_W +: BIN_W];
    end
  end

  assign req_ready = (rstn && (state_q == IDLE) && any_valid) ? grant_oh : '0;
  assign accept    = |(req_valid & req_ready);

  // Add-3 correction on every digit field, all from the current register value.
  logic [SH_W-1:0] adj;
  logic [SH_W-1:0] shifted;

  assign adj[BIN_W-1:0] = shift_q[BIN_W-1:0];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] dig;
    assign dig = shift_q[BIN_W + 4*gi +: 4];
    assign adj[BIN_W + 4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
  end
  assign shifted = {adj[SH_W-2:0], 1'b0};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    out_bcd_d    = out_bcd_q;
    out_id_d     = out_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d      = {{BCD_W{1'b0}}, sel_bin};
          cnt_d        = '0;
          id_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = CONV;
        end
      end
      CONV: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          out_bcd_d = shifted[SH_W-1 -: BCD_W];
          out_id_d  = id_q;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NREQ - 1);
      id_q         <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      out_bcd_q    <= '0;
      out_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      out_bcd_q    <= out_bcd_d;
      out_id_q     <= out_id_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_bcd   = out_bcd_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: expected results are queued at each
// accept and compared when the converter presents its output.
module tb_bcd_conv_arbiter;
  localparam int NREQ   = 2;
  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int ID_W   = 1;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*BIN_W-1:0] req_bin;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [ID_W-1:0]       out_id;
  logic                  busy;

  bcd_conv_arbiter #(.NREQ(NREQ), .BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int to_bcd(input int v);
    int r = 0;
    for (int d = 0; d < DIGITS; d++) begin
      r = r | ((v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard / monitor, sampled on the falling edge.
  int   sb_bcd[$];
  int   sb_id[$];
  int   n_acc = 0, n_pop = 0;
  int   acc_edge = 0, last_acc_id = -1, last_acc_val = -1;
  int   alt_prev = -1;
  logic have_prev = 1'b0, prev_ov = 1'b0;
  logic spacing_chk = 1'b0, alt_chk = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      sb_bcd.delete();
      sb_id.delete();
      prev_ov = 1'b0;
    end else begin
      if (!spacing_chk) have_prev = 1'b0;
      if (!alt_chk) alt_prev = -1;
      check("ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb_bcd.push_back(to_bcd(int'(req_bin[i*BIN_W +: BIN_W])));
          sb_id.push_back(i);
          if (have_prev) check("accept_spacing", cyc + 1 - acc_edge, BIN_W + 2);
          have_prev    = 1'b1;
          acc_edge     = cyc + 1;
          last_acc_id  = i;
          last_acc_val = int'(req_bin[i*BIN_W +: BIN_W]);
          n_acc++;
        end
      end
      if (out_valid && !prev_ov) check("latency", cyc - acc_edge, BIN_W);
      if (out_valid && out_ready) begin
        if (sb_bcd.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("out_bcd", int'(out_bcd), sb_bcd.pop_front());
          check("out_id", int'(out_id), sb_id.pop_front());
          if (alt_chk && alt_prev >= 0) check("alternate_id", int'(out_id), 1 - alt_prev);
          if (alt_chk) alt_prev = int'(out_id);
        end
        n_pop++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic wait_acc(input int target);
    int t = 0;
    while (n_acc < target && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (n_acc < target) check("accept_timeout", n_acc, target);
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || sb_bcd.size() != 0) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic single(input int v, input int exp_bcd);
    @(posedge clk); #1;
    req_bin[BIN_W-1:0] = BIN_W'(v);
    req_valid = 2'b01;
    wait_acc(n_acc + 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    check("single_bcd", int'(out_bcd), exp_bcd);
    check("single_id", int'(out_id), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, v1, acc_before, pop_before;
    rstn      = 1'b0;
    req_valid = 2'b11;
    req_bin   = {8'd5, 8'd7};
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_bcd", int'(out_bcd), 0);
    check("rst_out_id", int'(out_id), 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rstn = 1'b1;

    single(0,   12'h000);
    single(99,  12'h099);
    single(100, 12'h100);
    single(255, 12'h255);

    // Exhaustive sweep: req 0 carries even values, req 1 odd values.
    @(posedge clk); #1;
    v0 = 0; v1 = 1;
    req_bin = {8'(v1), 8'(v0)};
    spacing_chk = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 256; k++) begin
      wait_acc(n_acc + 1);
      @(posedge clk); #1;
      if (last_acc_id == 0) begin
        v0 += 2;
        if (v0 > 255) req_valid[0] = 1'b0; else req_bin[7:0] = 8'(v0);
      end else begin
        v1 += 2;
        if (v1 > 255) req_valid[1] = 1'b0; else req_bin[15:8] = 8'(v1);
      end
    end
    req_valid = 2'b00;
    wait_idle();
    spacing_chk = 1'b0;

    // Both requesters continuously valid: grants must alternate.
    @(posedge clk); #1;
    alt_chk = 1'b1;
    req_bin = {8'd200, 8'd12};
    req_valid = 2'b11;
    wait_acc(n_acc + 6);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
    alt_chk = 1'b0;

    // Output stall with a competing request pending.
    @(posedge clk); #1;
    req_bin[7:0] = 8'd57;
    req_valid = 2'b01;
    out_ready = 1'b0;
    wait_acc(n_acc + 1);
    @(posedge clk); #1;
    req_bin[15:8] = 8'd33;
    req_valid = 2'b10;
    wait_ov();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1);
      check("stall_bcd", int'(out_bcd), 12'h057);
      check("stall_id", int'(out_id), 0);
      check("stall_ready", int'(req_ready), 0);
    end
    pop_before = n_pop;
    acc_before = n_acc;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    wait_acc(acc_before + 1);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (12) @(negedge clk);
    check("stall_one_transfer", n_pop - pop_before, 1);
    check("stall_next_pending", int'(out_valid), 1);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // A requester drops valid in the same IDLE cycle another raises it.
    @(posedge clk); #1;
    out_ready = 1'b0;
    req_bin[15:8] = 8'd9;
    req_valid = 2'b10;
    wait_acc(n_acc + 1);
    @(posedge clk); #1;
    req_bin[7:0] = 8'd222;
    req_valid = 2'b01;
    wait_ov();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 2'b10;
    req_bin[15:8] = 8'd44;
    acc_before = n_acc;
    @(negedge clk);
    check("drop_grant", int'(req_ready), 2'b10);
    #1;
    wait_acc(acc_before + 1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
    check("drop_acc_id", last_acc_id, 1);
    check("drop_acc_val", last_acc_val, 44);
    check("drop_acc_count", n_acc - acc_before, 1);

    // Asynchronous reset in the middle of converting 173.
    @(posedge clk); #1;
    req_bin[7:0] = 8'd173;
    req_valid = 2'b01;
    wait_acc(n_acc + 1);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_out_bcd", int'(out_bcd), 0);
    check("arst_out_id", int'(out_id), 0);
    check("arst_req_ready", int'(req_ready), 0);
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("no_stale_result", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    req_bin = {8'd5, 8'd173};
    req_valid = 2'b11;
    @(negedge clk);
    check("post_rst_first_grant", int'(req_ready), 2'b01);
    #1;
    wait_acc(n_acc + 1);
    @(posedge clk); #1 req_valid = 2'b10;
    wait_acc(n_acc + 1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle();
    check("post_rst_last_bcd", int'(out_bcd), 12'h005);
    check("post_rst_last_id", int'(out_id), 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
